fetch_pc_controller: RTL and testbench

//  Sequences the program counter and instruction-memory fetch for the pipelined RISC-V core.
//  - Owns the fetch PC register.
//  - Chooses the next PC from: sequential (+4), EX-stage branch/jump redirect, trap vector, or stall-hold.
//  - Drives a req/ack handshake to instruction memory.
//  - Presents the fetched instruction to the IF/ID register with valid/stall semantics.

---
 rtl/fetch_pc_controller.sv | 176 +++++++++++++++++
 tb/tb_fetch_pc_controller.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_controller.sv
// fetch_pc_controller: owns the fetch PC and sequences instruction-memory requests
// for the pipelined RISC-V core. It presents fetched instructions to IF/ID with
// valid/stall semantics and handles EX redirects and trap entry.
// Optional feature macro: MISALIGN_CHK_EN (a misaligned redirect target becomes a
// trap). When it is undefined, the low two target bits are cleared and misalign_o
// stays 0.
module fetch_pc_controller #(
   parameter int               XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
   parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(32'h100)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            trap_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic [XLEN-1:0] pc_o,
   output logic            if_valid_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic [XLEN-1:0] if_instr_o,
   output logic            flush_o,
   output logic            misalign_o
);

   typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DRAIN} state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_req;
   logic [XLEN-1:0] r_addr;
   logic            r_if_valid;
   logic [XLEN-1:0] r_if_pc;
   logic [XLEN-1:0] r_if_instr;
   logic            r_flush;
   logic            r_misalign;
   // One-entry skid buffer. It catches an ack that lands while ID is stalled on a
   // valid instruction, because memory cannot be back-pressured once it has acked.
   logic            r_hold_v;
   logic [XLEN-1:0] r_hold_pc;
   logic [XLEN-1:0] r_hold_instr;

   logic            w_ack;
   logic            w_outst;
   logic            w_evt;
   logic            w_mis;
   logic [XLEN-1:0] w_tgt;
   logic [XLEN-1:0] w_pc_inc;
   logic [XLEN-1:0] w_pc_nxt;
   logic            w_slot_free;
   logic            w_hold_v_nxt;
   logic            w_issue;

   // Handshake status and redirect target selection (trap beats redirect).
   always_comb begin
      w_ack   = r_req & imem_ack_i;
      w_outst = r_req & ~imem_ack_i;
      w_evt   = trap_i | redirect_i;
`ifdef MISALIGN_CHK_EN
      w_mis   = redirect_i & ~trap_i & (redirect_pc_i[1:0] != 2'b00);
      w_tgt   = (trap_i | w_mis) ? TRAP_VECTOR : redirect_pc_i;
`else
      w_mis   = 1'b0;
      w_tgt   = trap_i ? TRAP_VECTOR : {redirect_pc_i[XLEN-1:2], 2'b00};
`endif
   end

`ifndef MISALIGN_CHK_EN
   logic w_unused_low_bits;
   assign w_unused_low_bits = ^redirect_pc_i[1:0];
`endif

   // Sequential PC, slot occupancy and issue decision for the FETCH state.
   always_comb begin
      w_pc_inc     = r_pc + XLEN'(4);
      w_pc_nxt     = w_ack ? w_pc_inc : r_pc;
      w_slot_free  = ~r_if_valid | ~stall_i;
      w_hold_v_nxt = w_slot_free ? (r_hold_v & w_ack) : (r_hold_v | w_ack);
      w_issue      = ~w_outst & w_slot_free & ~w_hold_v_nxt;
   end

   // Fetch FSM, PC register, request and IF/ID output slot, all registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_BOOT;
         r_pc         <= RESET_VECTOR;
         r_req        <= 1'b0;
         r_addr       <= RESET_VECTOR;
         r_if_valid   <= 1'b0;
         r_if_pc      <= '0;
         r_if_instr   <= '0;
         r_flush      <= 1'b0;
         r_misalign   <= 1'b0;
         r_hold_v     <= 1'b0;
         r_hold_pc    <= '0;
         r_hold_instr <= '0;
      end else begin
         r_flush    <= 1'b0;
         r_misalign <= 1'b0;
         case (r_state)
            // A late ack from before reset is ignored here because no request is live.
            S_BOOT: r_state <= S_FETCH;

            S_FETCH: begin
               if (w_evt) begin
                  r_pc       <= w_tgt;
                  r_flush    <= 1'b1;
                  r_misalign <= w_mis;
                  r_if_valid <= 1'b0;
                  r_hold_v   <= 1'b0;
                  if (w_outst) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_req  <= 1'b1;
                     r_addr <= w_tgt;
                  end
               end else begin
                  r_pc <= w_pc_nxt;
                  if (w_slot_free) begin
                     if (r_hold_v) begin
                        r_if_valid <= 1'b1;
                        r_if_pc    <= r_hold_pc;
                        r_if_instr <= r_hold_instr;
                     end else if (w_ack) begin
                        r_if_valid <= 1'b1;
                        r_if_pc    <= r_addr;
                        r_if_instr <= imem_rdata_i;
                     end else begin
                        r_if_valid <= 1'b0;
                     end
                  end
                  if (w_ack && (r_hold_v || !w_slot_free)) begin
                     r_hold_pc    <= r_addr;
                     r_hold_instr <= imem_rdata_i;
                  end
                  r_hold_v <= w_hold_v_nxt;
                  if (!w_outst) begin
                     r_req <= w_issue;
                     if (w_issue) r_addr <= w_pc_nxt;
                  end
               end
            end

            // Old request stays on the bus until acked; its data is dropped.
            S_DRAIN: begin
               if (w_evt) begin
                  r_pc       <= w_tgt;
                  r_flush    <= 1'b1;
                  r_misalign <= w_mis;
               end
               if (w_ack) begin
                  r_state <= S_FETCH;
                  r_req   <= 1'b1;
                  r_addr  <= w_evt ? w_tgt : r_pc;
               end
            end

            default: r_state <= S_BOOT;
         endcase
      end
   end

   assign imem_req_o  = r_req;
   assign imem_addr_o = r_addr;
   assign pc_o        = r_pc;
   assign if_valid_o  = r_if_valid;
   assign if_pc_o     = r_if_pc;
   assign if_instr_o  = r_if_instr;
   assign flush_o     = r_flush;
   assign misalign_o  = r_misalign;

endmodule

// File: tb/tb_fetch_pc_controller.sv
// Bench for fetch_pc_controller: directed vectors, a queue-based reference model,
// a per-cycle compare process and literal spot checks.
module tb_fetch_pc_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        trap_i = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic [31:0] pc_o;
   logic        if_valid_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_instr_o;
   logic        flush_o;
   logic        misalign_o;

   fetch_pc_controller dut (
      .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i), .trap_i(trap_i), .imem_req_o(imem_req_o),
      .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
      .pc_o(pc_o), .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_instr_o(if_instr_o),
      .flush_o(flush_o), .misalign_o(misalign_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Memory responder: acks after ack_delay waiting cycles; data derived from address.
   int   ack_delay = 0;
   int   wcnt = 0;
   logic force_ack = 1'b0;
   always @(posedge clk) begin
      #1;
      if (imem_req_o && !reset) begin
         if (wcnt >= ack_delay) begin
            imem_ack_i = 1'b1;
            wcnt = 0;
         end else begin
            imem_ack_i = 1'b0;
            wcnt++;
         end
      end else begin
         imem_ack_i = force_ack;
         wcnt = 0;
      end
      imem_rdata_i = imem_addr_o ^ 32'hC0DE_0013;
   end

   // Reference model: fetched instructions wait in a queue until ID takes them.
   logic [31:0] m_pc = '0, m_addr = '0, m_ifpc = '0, m_ifinstr = '0;
   logic        m_req = 1'b0, m_valid = 1'b0, m_flush = 1'b0, m_mis = 1'b0;
   logic        m_boot = 1'b1, m_drain = 1'b0;
   logic [63:0] m_q[$];

   always @(posedge clk or posedge reset) begin
      logic evt, done, outst, sf, mis;
      logic [31:0] tgt;
      if (reset) begin
         m_pc = '0; m_addr = '0; m_ifpc = '0; m_ifinstr = '0;
         m_req = 0; m_valid = 0; m_flush = 0; m_mis = 0;
         m_boot = 1; m_drain = 0; m_q.delete();
      end else begin
         evt   = trap_i | redirect_i;
         done  = m_req & imem_ack_i;
         outst = m_req & ~imem_ack_i;
`ifdef MISALIGN_CHK_EN
         mis = redirect_i && !trap_i && (redirect_pc_i % 4 != 0);
         tgt = (trap_i || mis) ? 32'h100 : redirect_pc_i;
`else
         mis = 1'b0;
         tgt = trap_i ? 32'h100 : (redirect_pc_i / 4) * 4;
`endif
         m_flush = 0;
         m_mis   = 0;
         if (m_boot) begin
            m_boot = 0;
         end else if (m_drain) begin
            if (evt) begin m_pc = tgt; m_flush = 1; m_mis = mis; end
            if (done) begin m_drain = 0; m_req = 1; m_addr = m_pc; end
         end else if (evt) begin
            m_pc = tgt; m_flush = 1; m_mis = mis; m_valid = 0; m_q.delete();
            if (outst) m_drain = 1;
            else begin m_req = 1; m_addr = tgt; end
         end else begin
            sf = !m_valid || !stall_i;
            if (done) begin
               m_q.push_back({m_addr, imem_rdata_i});
               m_pc = m_pc + 4;
            end
            if (sf) begin
               if (m_q.size() > 0) begin
                  {m_ifpc, m_ifinstr} = m_q.pop_front();
                  m_valid = 1;
               end else m_valid = 0;
            end
            if (!outst) begin
               if (sf && m_q.size() == 0) begin m_req = 1; m_addr = m_pc; end
               else m_req = 0;
            end
         end
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      chk("pc_o", pc_o, m_pc);
      chk("imem_req_o", {31'b0, imem_req_o}, {31'b0, m_req});
      chk("imem_addr_o", imem_addr_o, m_addr);
      chk("if_valid_o", {31'b0, if_valid_o}, {31'b0, m_valid});
      chk("if_pc_o", if_pc_o, m_ifpc);
      chk("if_instr_o", if_instr_o, m_ifinstr);
      chk("flush_o", {31'b0, flush_o}, {31'b0, m_flush});
      chk("misalign_o", {31'b0, misalign_o}, {31'b0, m_mis});
   end

   logic [31:0] acked[$];
   always @(negedge clk) if (!reset && imem_req_o && imem_ack_i) acked.push_back(imem_addr_o);

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic find_outstanding(input string nm);
      int i;
      for (i = 0; i < 20; i++) begin
         if (imem_req_o && !imem_ack_i) break;
         step(1);
      end
      chk({nm, "_found"}, {31'b0, (i < 20)}, 32'd1);
   endtask

   task automatic wait_req(input string nm, input logic [31:0] a);
      int i;
      for (i = 0; i < 20; i++) begin
         if (imem_req_o && imem_addr_o == a) break;
         step(1);
      end
      chk({nm, "_req_seen"}, {31'b0, (i < 20)}, 32'd1);
   endtask

   initial begin
      logic [31:0] p, ins, a;
      logic [47:0] stall_pat, redir_pat;
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] p, ins, a;
      logic [47:0] stall_pat, redir_pat;
      step(2);
      chk("rst_req", {31'b0, imem_req_o}, 32'd0);
      chk("rst_addr", imem_addr_o, 32'h0);
      chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_flush", {31'b0, flush_o}, 32'd0);

      // Boot and sequential zero-wait stream
      reset = 1'b0;
      step(1);
      chk("boot_no_req", {31'b0, imem_req_o}, 32'd0);
      step(1);
      chk("first_req", {31'b0, imem_req_o}, 32'd1);
      chk("first_addr", imem_addr_o, 32'h0);
      step(4);
      chk("acked_cnt", {31'b0, (acked.size() >= 4)}, 32'd1);
      if (acked.size() >= 4) begin
         chk("seq0", acked[0], 32'h0);
         chk("seq1", acked[1], 32'h4);
         chk("seq2", acked[2], 32'h8);
         chk("seq3", acked[3], 32'hC);
      end
      chk("stream_valid", {31'b0, if_valid_o}, 32'd1);

      // Stall three cycles on a valid instruction
      p = if_pc_o; ins = if_instr_o;
      stall_i = 1'b1;
      step(1);
      chk("stall_req1", {31'b0, imem_req_o}, 32'd0);
      step(1);
      chk("stall_req2", {31'b0, imem_req_o}, 32'd0);
      chk("stall_pc2", if_pc_o, p);
      step(1);
      chk("stall_pc3", if_pc_o, p);
      chk("stall_instr3", if_instr_o, ins);
      chk("stall_req3", {31'b0, imem_req_o}, 32'd0);
      stall_i = 1'b0;
      step(1);
      chk("resume_pc", if_pc_o, p + 32'd4);
      chk("resume_req", {31'b0, imem_req_o}, 32'd1);
      chk("resume_addr", imem_addr_o, p + 32'd8);

      // Redirect to 0x40 while a slow request is outstanding
      ack_delay = 3;
      step(1);
      find_outstanding("drain");
      a = imem_addr_o;
      redirect_i = 1'b1; redirect_pc_i = 32'h40;
      step(1);
      redirect_i = 1'b0;
      chk("drain_flush", {31'b0, flush_o}, 32'd1);
      chk("drain_hold_addr", imem_addr_o, a);
      chk("drain_hold_req", {31'b0, imem_req_o}, 32'd1);
      chk("drain_pc", pc_o, 32'h40);
      wait_req("drain_40", 32'h40);

      // Two redirects during a drain: the later target wins
      step(1);
      find_outstanding("drain2");
      redirect_i = 1'b1; redirect_pc_i = 32'h200;
      step(1);
      redirect_pc_i = 32'h240;
      step(1);
      redirect_i = 1'b0;
      chk("drain2_pc", pc_o, 32'h240);
      wait_req("drain2_240", 32'h240);
      ack_delay = 0;
      step(4);

      // Trap and redirect together: trap wins
      trap_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h80;
      step(1);
      trap_i = 1'b0; redirect_i = 1'b0;
      chk("trap_pc", pc_o, 32'h100);
      chk("trap_flush", {31'b0, flush_o}, 32'd1);
      chk("trap_valid", {31'b0, if_valid_o}, 32'd0);
      chk("trap_addr", imem_addr_o, 32'h100);
      step(3);

      // PC wrap at the top of the address space
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
      step(1);
      redirect_i = 1'b0;
      chk("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
      step(1);
      chk("wrap_addr1", imem_addr_o, 32'h0);
      chk("wrap_pc", pc_o, 32'h0);
      chk("wrap_if_pc", if_pc_o, 32'hFFFF_FFFC);
      step(3);

      // Misaligned redirect target
      redirect_i = 1'b1; redirect_pc_i = 32'h42;
      step(1);
      redirect_i = 1'b0;
      chk("mis_flush", {31'b0, flush_o}, 32'd1);
`ifdef MISALIGN_CHK_EN
      chk("mis_flag", {31'b0, misalign_o}, 32'd1);
      chk("mis_addr", imem_addr_o, 32'h100);
`else
      chk("mis_flag", {31'b0, misalign_o}, 32'd0);
      chk("mis_addr", imem_addr_o, 32'h40);
`endif
      step(2);

      // Mixed stalls, redirects and memory latencies, checked by the model
      stall_pat = 48'h3C6_1B09_E471;
      redir_pat = 48'h010_0402_0800;
      for (int i = 0; i < 48; i++) begin
         stall_i       = stall_pat[i];
         redirect_i    = redir_pat[i];
         redirect_pc_i = 32'h300 + 32'(i * 8);
         ack_delay     = i % 3;
         step(1);
      end
      stall_i = 1'b0; redirect_i = 1'b0; ack_delay = 3;
      step(2);

      // Reset in the middle of an outstanding request, late ack in BOOT
      find_outstanding("mid_rst");
      reset = 1'b1;
      #1;
      chk("midrst_req", {31'b0, imem_req_o}, 32'd0);
      chk("midrst_addr", imem_addr_o, 32'h0);
      chk("midrst_valid", {31'b0, if_valid_o}, 32'd0);
      chk("midrst_pc", pc_o, 32'h0);
      ack_delay = 0;
      force_ack = 1'b1;
      step(1);
      reset = 1'b0;
      force_ack = 1'b0;
      step(1);
      chk("late_ack_req", {31'b0, imem_req_o}, 32'd0);
      chk("late_ack_pc", pc_o, 32'h0);
      step(1);
      chk("post_rst_addr", imem_addr_o, 32'h0);
      chk("post_rst_req", {31'b0, imem_req_o}, 32'd1);
      step(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
